// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
// daq_pkg
// Run-control command codes, default frame words and the packer state type.
// Revision: 1.0
// ============================================================================
package daq_pkg;

    localparam logic [7:0]  CMD_START     = 8'hFF;
    localparam logic [7:0]  CMD_RESET     = 8'hC0;
    localparam logic [7:0]  CMD_CLOSE     = 8'hC7;

    localparam logic [31:0] DEF_HEAD_WORD = 32'hAAAAAAAA;
    localparam logic [31:0] DEF_TAIL_WORD = 32'hF0F0F0F0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2,
        TAIL    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/daq_sample_pair.sv
`default_nettype none
// ============================================================================
// daq_sample_pair
// Pairs two 16-bit samples into one 32-bit word, first sample in the upper half.
// Revision: 1.0
// ============================================================================
module daq_sample_pair (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [15:0] i_data,
    output logic        o_done,
    output logic [31:0] o_word
);

    logic        half_q, half_d;
    logic [15:0] hi_q, hi_d;

    always_comb begin
        half_d = half_q;
        hi_d   = hi_q;
        if (i_clr) begin
            half_d = 1'b0;
            hi_d   = 16'd0;
        end else if (i_load) begin
            if (!half_q) begin
                hi_d   = i_data;
                half_d = 1'b1;
            end else begin
                half_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= 1'b0;
            hi_q   <= 16'd0;
        end else begin
            half_q <= half_d;
            hi_q   <= hi_d;
        end
    end

    // The second sample completes the word in the same cycle it is offered.
    assign o_done = i_load && half_q && !i_clr;
    assign o_word = {hi_q, i_data};

endmodule
`default_nettype wire

// File: rtl/daq_frame_packer.sv
`default_nettype none
// ============================================================================
// daq_frame_packer
// Packs 16-bit samples into HEAD / payload / TAIL frames for a capture FIFO.
// Optional macro DAQ_FRAME_SEQ_TAIL_EN: trailer low half carries frame_seq.
// Revision: 1.0
// ============================================================================
module daq_frame_packer
    import daq_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 24,
    parameter logic [31:0] HEAD_WORD     = DEF_HEAD_WORD,
    parameter logic [31:0] TAIL_WORD     = DEF_TAIL_WORD
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic [7:0]  cfg_cmd,
    input  logic        smp_valid,
    input  logic [15:0] smp_data,
    output logic        smp_ready,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [15:0] frame_seq,
    output logic        led_data
);

    localparam logic [7:0] LAST_CNT = 8'(PAYLOAD_WORDS - 1);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] seq_q, seq_d;

    logic        w_write;
    logic        w_xfer;
    logic        w_pair_clr;
    logic        w_pair_done;
    logic [31:0] w_pair_word;
    logic [31:0] w_trailer;

`ifdef DAQ_FRAME_SEQ_TAIL_EN
    assign w_trailer = {TAIL_WORD[31:16], seq_q};
`else
    assign w_trailer = TAIL_WORD;
`endif

    assign w_write    = pending_q && !fifo_full;
    assign smp_ready  = (state_q == PAYLOAD) && !pending_q;
    assign w_xfer     = smp_valid && smp_ready;
    assign w_pair_clr = (cfg_cmd == CMD_RESET);

    daq_sample_pair u_pair (
        .clk    (bus_clk),
        .rst_n  (bus_rst_n),
        .i_clr  (w_pair_clr),
        .i_load (w_xfer),
        .i_data (smp_data),
        .o_done (w_pair_done),
        .o_word (w_pair_word)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;

        case (state_q)
            IDLE: begin
                if (cfg_cmd == CMD_START) begin
                    state_d   = HEAD;
                    pending_d = 1'b1;
                    word_d    = HEAD_WORD;
                end
            end
            HEAD: begin
                if (w_write) begin
                    pending_d = 1'b0;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_write) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d     = 8'd0;
                        state_d   = TAIL;
                        pending_d = 1'b1;
                        word_d    = w_trailer;
                    end else begin
                        cnt_d     = cnt_q + 8'd1;
                        pending_d = 1'b0;
                    end
                end else if (w_pair_done) begin
                    word_d    = w_pair_word;
                    pending_d = 1'b1;
                end
            end
            TAIL: begin
                if (w_write) begin
                    seq_d = seq_q + 16'd1;
                    // Back-to-back frames reload the header directly.
                    if (cfg_cmd == CMD_START) begin
                        state_d   = HEAD;
                        pending_d = 1'b1;
                        word_d    = HEAD_WORD;
                    end else begin
                        state_d   = IDLE;
                        pending_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_cmd == CMD_RESET) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            word_d    = 32'd0;
            cnt_d     = 8'd0;
            seq_d     = 16'd0;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            word_q    <= 32'd0;
            cnt_q     <= 8'd0;
            seq_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
        end
    end

    assign fifo_din   = word_q;
    assign fifo_wr_en = w_write;
    assign led_data   = w_write;
    assign frame_seq  = seq_q;

endmodule
`default_nettype wire
